// File: rtl/ternary_word_seq.sv
// Serial balanced-ternary ALU: add/mul/min/max over TRITS-trit words, one trit per cycle LSB first.
// Result valid TRITS cycles after acceptance; held in HOLD until res_ready, no request queuing.
module ternary_word_seq #(
  parameter int TRITS = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [2*TRITS-1:0] a,
  input  logic [2*TRITS-1:0] b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*TRITS-1:0] result,
  output logic [1:0]         carry_out,
  output logic               err
);

  localparam int IW = (TRITS > 1) ? $clog2(TRITS) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state, state_nxt;
  logic [2*TRITS-1:0] a_q, b_q;
  logic [1:0]         op_q;
  logic [IW-1:0]      idx;
  logic [1:0]         carry;

  logic               accept, last;
  logic [1:0]         ta, tb;
  logic signed [2:0]  va, vb, vc, sum, dv;
  logic [1:0]         digit, carry_nxt;
  logic               bad;

  function automatic logic signed [2:0] t2v(input logic [1:0] t);
    case (t)
      2'b01:   t2v = 3'sd1;
      2'b10:   t2v = -3'sd1;
      default: t2v = 3'sd0;  // Z and the invalid code both count as zero
    endcase
  endfunction

  function automatic logic [1:0] v2t(input logic signed [2:0] v);
    if (v > 3'sd0)      v2t = 2'b01;
    else if (v < 3'sd0) v2t = 2'b10;
    else                v2t = 2'b00;
  endfunction

  assign accept = in_valid && (state == IDLE);
  assign last   = (idx == IW'(TRITS - 1));

  // Current trit datapath
  always_comb begin
    ta        = a_q[2*idx +: 2];
    tb        = b_q[2*idx +: 2];
    bad       = (ta == 2'b11) || (tb == 2'b11);
    va        = t2v(ta);
    vb        = t2v(tb);
    vc        = t2v(carry);
    sum       = va + vb + vc;
    dv        = 3'sd0;
    carry_nxt = 2'b00;
    case (op_q)
      OP_ADD: begin
        if (sum > 3'sd1) begin
          dv        = sum - 3'sd3;
          carry_nxt = 2'b01;
        end else if (sum < -3'sd1) begin
          dv        = sum + 3'sd3;
          carry_nxt = 2'b10;
        end else begin
          dv        = sum;
        end
      end
      OP_MUL:  dv = va * vb;
      OP_MIN:  dv = (va < vb) ? va : vb;
      default: dv = (va > vb) ? va : vb;
    endcase
    digit = v2t(dv);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      idx    <= '0;
      carry  <= 2'b00;
      result <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      op_q   <= op;
      idx    <= '0;
      carry  <= 2'b00;
      result <= '0;
      err    <= 1'b0;
    end else if (state == RUN) begin
      result[2*idx +: 2] <= digit;
      carry              <= carry_nxt;
      err                <= err | bad;
      idx                <= last ? '0 : idx + IW'(1);
    end
  end

  // Carry is only meaningful once the add has consumed its last trit
  assign carry_out = (state == HOLD && op_q == OP_ADD) ? carry : 2'b00;

endmodule

// File: tb/tb_ternary_word_seq.sv
// Directed bench for ternary_word_seq with TRITS=9 and hand-computed expectations.
module tb_ternary_word_seq;

  localparam int TRITS = 9;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [17:0] a;
  logic [17:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] result;
  logic [1:0]  carry_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  ternary_word_seq #(.TRITS(TRITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_out (carry_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request for one edge, then scramble the inputs so a design
  // that keeps sampling them after acceptance produces a wrong answer.
  task automatic start(input logic [1:0] o, input logic [17:0] x, input logic [17:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 2'($urandom);
    a        = 18'($urandom);
    b        = 18'($urandom);
  endtask

  task automatic wait_res(input string tag);
    int cnt = 0;
    while (!res_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_lat"}, cnt, TRITS);
  endtask

  task automatic release_res(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_rel_vld"}, res_valid, 1'b0);
    check({tag, "_rel_rdy"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [17:0] x,
                        input logic [17:0] y, input logic [17:0] exp_res,
                        input logic [1:0] exp_cy, input logic exp_err);
    start(o, x, y);
    check({tag, "_busy"}, in_ready, 1'b0);
    wait_res(tag);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_cy"}, carry_out, exp_cy);
    check({tag, "_err"}, err, exp_err);
    release_res(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", in_ready, 1'b1);
    check("rst_vld", res_valid, 1'b0);
    check("rst_res", result, 18'h0);
    check("rst_cy", carry_out, 2'b00);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // Acceptance on the very first edge after reset release
    run_op("add1", 2'b00, 18'h00001, 18'h00001, 18'h00006, 2'b00, 1'b0);
    run_op("addp", 2'b00, 18'h15555, 18'h15555, 18'h00002, 2'b01, 1'b0);
    run_op("mul",  2'b01, 18'h15555, 18'h2AAAA, 18'h2AAAA, 2'b00, 1'b0);
    run_op("min",  2'b10, 18'h15555, 18'h2AAAA, 18'h2AAAA, 2'b00, 1'b0);
    run_op("max",  2'b11, 18'h15555, 18'h2AAAA, 18'h15555, 2'b00, 1'b0);
    run_op("inv",  2'b00, 18'h00003, 18'h00001, 18'h00001, 2'b00, 1'b1);
    run_op("clr",  2'b00, 18'h00001, 18'h00001, 18'h00006, 2'b00, 1'b0);
    // -1 + -1 = -2 -> trit0 P, carry N into trit1 -> N
    run_op("addn", 2'b00, 18'h00002, 18'h00002, 18'h00009, 2'b00, 1'b0);
    // Overflowing negative add: all N + all N
    run_op("addm", 2'b00, 18'h2AAAA, 18'h2AAAA, 18'h00001, 2'b10, 1'b0);

    // HOLD stalls with in_valid pulsing
    start(2'b00, 18'h00001, 18'h00001);
    wait_res("hold");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op       = 2'b01;
      a        = 18'h15555;
      b        = 18'h15555;
      @(posedge clk);
      #1;
      check("hold_res", result, 18'h00006);
      check("hold_vld", res_valid, 1'b1);
      check("hold_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    release_res("hold");
    start(2'b10, 18'h15555, 18'h2AAAA);
    check("b2b_busy", in_ready, 1'b0);
    wait_res("b2b");
    check("b2b_res", result, 18'h2AAAA);
    release_res("b2b");

    // Reset while RUN is at index 4
    start(2'b00, 18'h00001, 18'h00001);
    repeat (4) @(posedge clk);
    #1;
    check("mid_partial", result, 18'h00006);
    rst_n = 1'b0;
    #1;
    check("mid_rdy", in_ready, 1'b1);
    check("mid_vld", res_valid, 1'b0);
    check("mid_res", result, 18'h0);
    check("mid_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("post", 2'b00, 18'h15555, 18'h15555, 18'h00002, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
